pwm_multichannel_gen: RTL

//  N-channel parametrised PWM generator; successor to the fixed 2-channel, 7-bit, 4-level motor PWM block.
//  One shared period counter drives N compare channels.

---
 rtl/pwm_multichannel_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/pwm_multichannel_gen.sv
// pwm_multichannel_gen
// N-channel PWM generator driven by one shared period counter. The terminal
// count, per-channel duty and per-channel direction are shadow-loaded on the
// last clock of each period, so a command never disturbs a running period.
// After a direction reversal each channel is held off for DEAD_CYC clocks,
// which protects the H-bridge. The outputs are registered, so they lag the
// counter by one clock.
module pwm_multichannel_gen #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 7,
    parameter int TOP_RST  = 127,
    parameter int DEAD_CYC = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [CNT_W-1:0]        top_in,
    input  logic [N_CH*CNT_W-1:0]   duty_in,
    input  logic [N_CH-1:0]         dir_in,
    output logic [2*N_CH-1:0]       motor_out,
    output logic                    period_start
);

    // The dead counter must hold DEAD_CYC. It keeps one bit even when
    // dead-time is disabled.
    localparam int               DW        = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_CYC);
    localparam logic [CNT_W-1:0] TOP_INIT  = CNT_W'(TOP_RST);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_top;
    logic [2*N_CH-1:0] r_motor;
    logic              r_period_start;

    logic              w_load;
    logic [CNT_W-1:0]  w_top_clamped;
    logic [N_CH-1:0]   w_on_g;
    logic [N_CH-1:0]   w_dir;

    // The last clock of the period is the shadow-load point. A requested top
    // of 0 is raised to 1, so a period is never shorter than 2 clocks.
    assign w_load        = (r_cnt == r_top);
    assign w_top_clamped = (top_in == '0) ? CNT_W'(1) : top_in;

    // Shared period counter. The terminal count is reloaded at the wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_top <= TOP_INIT;
        end else if (w_load) begin
            r_cnt <= '0;
            r_top <= w_top_clamped;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_duty;
            logic             r_dir;
            logic [DW-1:0]    r_dead;

            // Shadow-load duty and direction. A reversal restarts the
            // dead-time countdown; otherwise the countdown runs towards zero.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_duty <= '0;
                    r_dir  <= 1'b0;
                    r_dead <= '0;
                end else begin
                    if (w_load) begin
                        r_duty <= duty_in[gi*CNT_W +: CNT_W];
                        r_dir  <= dir_in[gi];
                    end
                    if (w_load && (dir_in[gi] != r_dir)) begin
                        r_dead <= DEAD_LOAD;
                    end else if (r_dead != '0) begin
                        r_dead <= r_dead - DW'(1);
                    end
                end
            end

            // The channel is on while the counter is below the duty value and
            // the channel is not in dead-time. A duty above top gives 100%.
            assign w_on_g[gi] = (r_cnt < r_duty) && (r_dead == '0);
            assign w_dir[gi]  = r_dir;
        end
    endgenerate

    // Output register. The direction picks exactly one leg, so both legs of
    // a channel can never be high at the same time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_motor        <= '0;
            r_period_start <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_motor[2*i]   <= w_on_g[i] & ~w_dir[i];
                r_motor[2*i+1] <= w_on_g[i] &  w_dir[i];
            end
            r_period_start <= (r_cnt == '0);
        end
    end

    assign motor_out    = r_motor;
    assign period_start = r_period_start;

endmodule
